shift_issue_stage: RTL and testbench
====================================

// Module: shift_issue_stage
// PURPOSE
//  Pipeline stage directly upstream of full_left_logical_shifter / full_right_logical_shifter.
//  Accepts a decoded R-type instruction plus register operands and decodes the shift
//  funct field. Registers the shifter operands (A, shamt, direction) behind a valid/ready
//  handshake. A 2-entry skid buffer lets the downstream shifter stall without combinational
//  ready paths.
// PARAMETERS
//  DATA_W   32  operand width; shamt width is fixed at 5 (DATA_W must be 32)
//  CNT_W    16  width of the accepted-shift counter
// PORTS
//  clk          in   1       single clock, all state on rising edge
//  reset        in   1       synchronous, active-high
//  in_valid     in   1       upstream instruction valid
//  in_ready     out  1       stage can accept (registered)
//  in_instr     in   32      instruction word: [31:26] opcode, [15:11] rd, [10:6] shamt, [5:0] funct
//  in_rs        in   DATA_W  rs register value (variable shift amount source)
//  in_rt        in   DATA_W  rt register value (value to be shifted)
//  out_valid    out  1       shifter operands valid
//  out_ready    in   1       shifter/consumer accepts
//  out_a        out  DATA_W  value to shift (= rt)
//  out_b        out  5       shift amount
//  out_left     out  1       1 = logical left, 0 = logical right
//  out_rd       out  5       destination register
//  out_illegal  out  1       instruction is not a supported shift; consumer drops it
//  shift_count  out  CNT_W   number of legal shifts delivered (saturating)
// BEHAVIOUR
//  - Reset: out_valid=0, out_a=0, out_b=0, out_left=0, out_rd=0, out_illegal=0,
//    shift_count=0, in_ready=1. Both buffer entries are emptied; in-flight data is discarded.
//  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//  - Latency: 1 cycle from input transfer to out_valid when the stage is empty.
//  - Storage: main register (drives outputs) + skid register.
//    - in_ready = skid entry empty.
//    - Input transfer while main is empty, or main is draining this cycle: the input loads main.
//    - Input transfer while main is held (out_valid & !out_ready): the input loads skid.
//    - Out transfer with skid full: skid moves to main; in_ready returns to 1 the next cycle.
//    - Simultaneous in and out transfer with skid empty: main is replaced and throughput stays 1/cycle.
//  - Order is preserved. No beat is dropped or duplicated.
//  - Decode (opcode must be 6'h00):
//    - SLL  funct 6'h00: b = shamt, left = 1
//    - SRL  funct 6'h02: b = shamt, left = 0
//    - SLLV funct 6'h04 / SRLV funct 6'h06: see CONFIGURATION
//    - Any other opcode/funct: out_illegal = 1, b = 0, left = 0, a = rt.
//  - shift_count increments by 1 on each out transfer with out_illegal=0.
//    It saturates at all-ones and never wraps.
//  - Outputs are stable while out_valid & !out_ready.
// CONFIGURATION
//  SHIFT_VAR_EN defined:
//    - SLLV/SRLV are legal.
//    - b = in_rs[4:0]; upper rs bits are ignored. left = 1 for SLLV, 0 for SRLV.
//  SHIFT_VAR_EN undefined:
//    - SLLV/SRLV decode as illegal (out_illegal=1, b=0).
//    - in_rs is unused.
// STRUCTURE
//  - shift_pkg.vh holds the shared constants: OPC_RTYPE, FUNCT_SLL/SRL/SLLV/SRLV, SHAMT_W=5.
//    The decoder and the testbench both include it.
//  - Sub-module shift_issue_decode: combinational instr/rs -> {illegal, left, b, rd}.
//    It is instantiated once, on the input side.
//  - This module holds the skid buffer, handshake control and counter.
// TESTING
//  1. Reset mid-stream:
//     - Stimulus: fill both entries, assert reset for 1 cycle.
//     - Response: out_valid=0, in_ready=1, shift_count=0 the next cycle.
//  2. SLL:
//     - Stimulus: instr=32'h000A1100 (rd=2, shamt=4, SLL), rt=32'h55555555, out_ready=1.
//     - Response: the next cycle out_a=32'h55555555, out_b=4, out_left=1, out_rd=2,
//       out_illegal=0; shift_count=1 after the transfer.
//  3. Backpressure:
//     - Stimulus: 3 back-to-back SRL beats with shamt 1,2,3, out_ready=0.
//     - Response: first beat in main, second in skid, in_ready=0 (third held upstream).
//       Raise out_ready: beats emerge in order with b=1,2,3 and none lost.
//  4. Streaming:
//     - Stimulus: 32 SRL beats, shamt=i, rt=32'hAAAAAAAA, out_ready=1.
//     - Response: one output per cycle, b=i, left=0.
//  5. Illegal:
//     - Stimulus: opcode 6'h08 or funct 6'h20.
//     - Response: out_illegal=1, b=0, shift_count unchanged.
//  6. SLLV:
//     - Stimulus: SLLV with rs=32'hFFFFFFE7.
//     - Response with SHIFT_VAR_EN: b=7, left=1.
//     - Response without it: out_illegal=1.
//  7. Saturation:
//     - Stimulus: CNT_W=2, five legal beats.
//     - Response: shift_count stays at 3.

Source files
------------

// File: rtl/shift_issue_stage_pkg.sv
// Shared encodings and the decoded-operand record for the shift issue stage.
package shift_issue_stage_pkg;

  localparam int SHAMT_W = 5;

  localparam logic [5:0] OPC_RTYPE  = 6'h00;
  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;

  typedef struct packed {
    logic               illegal;
    logic               left;
    logic [SHAMT_W-1:0] b;
    logic [4:0]         rd;
  } shift_op_t;

endpackage

// File: rtl/shift_issue_stage_decode.sv
// Combinational shift decoder: instruction word and rs value -> {illegal, left, b, rd}.
// Variable shifts (SLLV/SRLV) are legal only when SHIFT_VAR_EN is defined.
module shift_issue_stage_decode
  import shift_issue_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs,
  output shift_op_t         op
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_bits;

  assign opcode      = instr[31:26];
  assign funct       = instr[5:0];
  assign unused_bits = ^{instr[25:16], rs};

  // Anything not recognised falls through as illegal with a zero shift amount
  always_comb begin
    op         = '0;
    op.illegal = 1'b1;
    op.rd      = instr[15:11];
    if (opcode == OPC_RTYPE) begin
      case (funct)
        FUNCT_SLL: begin
          op.illegal = 1'b0;
          op.left    = 1'b1;
          op.b       = instr[10:6];
        end
        FUNCT_SRL: begin
          op.illegal = 1'b0;
          op.left    = 1'b0;
          op.b       = instr[10:6];
        end
`ifdef SHIFT_VAR_EN
        FUNCT_SLLV: begin
          op.illegal = 1'b0;
          op.left    = 1'b1;
          op.b       = rs[SHAMT_W-1:0];
        end
        FUNCT_SRLV: begin
          op.illegal = 1'b0;
          op.left    = 1'b0;
          op.b       = rs[SHAMT_W-1:0];
        end
`else
        FUNCT_SLLV, FUNCT_SRLV: begin
          op.illegal = 1'b1;
        end
`endif
        default: begin
          op.illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_issue_stage.sv
// Shift issue stage: decodes shift instructions and hands operands to the shifter through
// a main + skid register pair. Optional variable shifts are enabled by SHIFT_VAR_EN.
module shift_issue_stage
  import shift_issue_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [DATA_W-1:0]  in_rs,
  input  logic [DATA_W-1:0]  in_rt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_a,
  output logic [SHAMT_W-1:0] out_b,
  output logic               out_left,
  output logic [4:0]         out_rd,
  output logic               out_illegal,
  output logic [CNT_W-1:0]   shift_count
);

  shift_op_t         dec_op;
  shift_op_t         main_op_q, main_op_d, skid_op_q, skid_op_d;
  logic [DATA_W-1:0] main_a_q, main_a_d, skid_a_q, skid_a_d;
  logic              main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_xfer, out_xfer;

  shift_issue_stage_decode #(.DATA_W(DATA_W)) u_decode (
    .instr (in_instr),
    .rs    (in_rs),
    .op    (dec_op)
  );

  assign in_ready    = !skid_valid_q;
  assign in_xfer     = in_valid && in_ready;
  assign out_xfer    = main_valid_q && out_ready;
  assign out_valid   = main_valid_q;
  assign out_a       = main_a_q;
  assign out_b       = main_op_q.b;
  assign out_left    = main_op_q.left;
  assign out_rd      = main_op_q.rd;
  assign out_illegal = main_op_q.illegal;
  assign shift_count = cnt_q;

  // A full skid implies a full main, so skid only refills main on an output transfer
  always_comb begin
    main_valid_d = main_valid_q;
    main_op_d    = main_op_q;
    main_a_d     = main_a_q;
    skid_valid_d = skid_valid_q;
    skid_op_d    = skid_op_q;
    skid_a_d     = skid_a_q;
    cnt_d        = cnt_q;
    if (out_xfer || !main_valid_q) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_op_d    = skid_op_q;
        main_a_d     = skid_a_q;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        main_valid_d = 1'b1;
        main_op_d    = dec_op;
        main_a_d     = in_rt;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_valid_d = 1'b1;
      skid_op_d    = dec_op;
      skid_a_d     = in_rt;
    end
    if (out_xfer && !main_op_q.illegal && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_op_q    <= '0;
      main_a_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_op_q    <= '0;
      skid_a_q     <= '0;
      cnt_q        <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_op_q    <= main_op_d;
      main_a_q     <= main_a_d;
      skid_valid_q <= skid_valid_d;
      skid_op_q    <= skid_op_d;
      skid_a_q     <= skid_a_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage; a second instance with CNT_W=2 covers counter saturation.
module tb_shift_issue_stage;
  import shift_issue_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_rs;
  logic [31:0] in_rt;
  logic        out_ready;
  logic        in_ready, out_valid, out_left, out_illegal;
  logic [31:0] out_a;
  logic [4:0]  out_b, out_rd;
  logic [15:0] shift_count;
  logic        sat_in_ready, sat_out_valid, sat_out_left, sat_out_illegal;
  logic [31:0] sat_out_a;
  logic [4:0]  sat_out_b, sat_out_rd;
  logic [1:0]  sat_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_cnt      = 0;

  always #5 clk = ~clk;

  shift_issue_stage #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs(in_rs), .in_rt(in_rt), .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
    .out_b(out_b), .out_left(out_left), .out_rd(out_rd), .out_illegal(out_illegal),
    .shift_count(shift_count)
  );

  shift_issue_stage #(.DATA_W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(sat_in_ready), .in_instr(in_instr),
    .in_rs(in_rs), .in_rt(in_rt), .out_valid(sat_out_valid), .out_ready(out_ready), .out_a(sat_out_a),
    .out_b(sat_out_b), .out_left(sat_out_left), .out_rd(sat_out_rd), .out_illegal(sat_out_illegal),
    .shift_count(sat_count)
  );

  function automatic logic [31:0] mk_instr(input logic [5:0] opc, input logic [4:0] rd,
                                           input logic [4:0] shamt, input logic [5:0] funct);
    return {opc, 10'd0, rd, shamt, funct};
  endfunction

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_rs = '0; in_rt = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready); end
    tests_run++; if (shift_count !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset_count: got %0d expected 0", shift_count); end
    tests_run++; if ({out_a, out_b, out_left, out_rd, out_illegal} !== 44'd0) begin tests_failed++; $display("[TB] FAIL reset_outputs: got a=%h b=%0d l=%0b rd=%0d ill=%0b expected all zero", out_a, out_b, out_left, out_rd, out_illegal); end
    exp_cnt = 0;
  endtask

  task automatic test_sll();
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h000A1100; in_rt = 32'h55555555; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL sll_valid: got %0b expected 1", out_valid); end
    tests_run++; if (out_a !== 32'h55555555) begin tests_failed++; $display("[TB] FAIL sll_a: got %h expected 55555555", out_a); end
    tests_run++; if (out_b !== 5'd4) begin tests_failed++; $display("[TB] FAIL sll_b: got %0d expected 4", out_b); end
    tests_run++; if (out_left !== 1'b1) begin tests_failed++; $display("[TB] FAIL sll_left: got %0b expected 1", out_left); end
    tests_run++; if (out_rd !== 5'd2) begin tests_failed++; $display("[TB] FAIL sll_rd: got %0d expected 2", out_rd); end
    tests_run++; if (out_illegal !== 1'b0) begin tests_failed++; $display("[TB] FAIL sll_illegal: got %0b expected 0", out_illegal); end
    tests_run++; if (shift_count !== 16'(exp_cnt)) begin tests_failed++; $display("[TB] FAIL sll_count_before: got %0d expected %0d", shift_count, exp_cnt); end
    @(negedge clk);
    exp_cnt++;
    tests_run++; if (shift_count !== 16'(exp_cnt)) begin tests_failed++; $display("[TB] FAIL sll_count_after: got %0d expected %0d", shift_count, exp_cnt); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL sll_drained: got %0b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_rt = 32'h12345678;
    in_valid = 1'b1; in_instr = mk_instr(OPC_RTYPE, 5'd1, 5'd1, FUNCT_SRL);
    @(negedge clk);
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_ready1: got %0b expected 1", in_ready); end
    in_instr = mk_instr(OPC_RTYPE, 5'd1, 5'd2, FUNCT_SRL);
    @(negedge clk);
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_ready_full: got %0b expected 0", in_ready); end
    tests_run++; if (out_b !== 5'd1) begin tests_failed++; $display("[TB] FAIL bp_main_b: got %0d expected 1", out_b); end
    in_instr = mk_instr(OPC_RTYPE, 5'd1, 5'd3, FUNCT_SRL);
    @(negedge clk);
    tests_run++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_hold_flags: got ready=%0b valid=%0b expected ready=0 valid=1", in_ready, out_valid); end
    tests_run++; if (out_b !== 5'd1 || out_left !== 1'b0 || out_a !== 32'h12345678) begin tests_failed++; $display("[TB] FAIL bp_stable: got b=%0d l=%0b a=%h expected b=1 l=0 a=12345678", out_b, out_left, out_a); end
    out_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (out_b !== 5'd2 || out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_second: got b=%0d valid=%0b expected b=2 valid=1", out_b, out_valid); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_ready_back: got %0b expected 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++; if (out_b !== 5'd3 || out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_third: got b=%0d valid=%0b expected b=3 valid=1", out_b, out_valid); end
    @(negedge clk);
    exp_cnt += 3;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_empty: got %0b expected 0", out_valid); end
    tests_run++; if (shift_count !== 16'(exp_cnt)) begin tests_failed++; $display("[TB] FAIL bp_count: got %0d expected %0d", shift_count, exp_cnt); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1; in_rt = 32'hAAAAAAAA;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      if (i > 0) begin
        tests_run++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL stream_flags[%0d]: got valid=%0b ready=%0b expected 1 1", i - 1, out_valid, in_ready); end
        tests_run++; if (out_b !== 5'(i - 1) || out_left !== 1'b0 || out_a !== 32'hAAAAAAAA) begin tests_failed++; $display("[TB] FAIL stream_beat[%0d]: got b=%0d l=%0b a=%h expected b=%0d l=0 a=aaaaaaaa", i - 1, out_b, out_left, out_a, i - 1); end
      end
      if (i < 32) begin
        in_valid = 1'b1; in_instr = mk_instr(OPC_RTYPE, 5'd9, 5'(i), FUNCT_SRL);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    exp_cnt += 32;
    tests_run++; if (out_valid !== 1'b0 || shift_count !== 16'(exp_cnt)) begin tests_failed++; $display("[TB] FAIL stream_end: got valid=%0b count=%0d expected 0 %0d", out_valid, shift_count, exp_cnt); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1; in_rt = 32'hDEADBEEF;
    @(negedge clk);
    in_valid = 1'b1; in_instr = mk_instr(6'h08, 5'd3, 5'd5, FUNCT_SLL);
    @(negedge clk);
    tests_run++; if (out_illegal !== 1'b1 || out_b !== 5'd0 || out_left !== 1'b0 || out_a !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL illegal_opcode: got ill=%0b b=%0d l=%0b a=%h expected 1 0 0 deadbeef", out_illegal, out_b, out_left, out_a); end
    in_instr = mk_instr(OPC_RTYPE, 5'd3, 5'd5, 6'h20);
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++; if (out_illegal !== 1'b1 || out_b !== 5'd0 || out_left !== 1'b0) begin tests_failed++; $display("[TB] FAIL illegal_funct: got ill=%0b b=%0d l=%0b expected 1 0 0", out_illegal, out_b, out_left); end
    @(negedge clk);
    tests_run++; if (shift_count !== 16'(exp_cnt)) begin tests_failed++; $display("[TB] FAIL illegal_count: got %0d expected %0d", shift_count, exp_cnt); end
  endtask

  task automatic test_sllv();
    out_ready = 1'b1; in_rt = 32'h0F0F0F0F; in_rs = 32'hFFFFFFE7;
    @(negedge clk);
    in_valid = 1'b1; in_instr = mk_instr(OPC_RTYPE, 5'd6, 5'd3, FUNCT_SLLV);
    @(negedge clk);
`ifdef SHIFT_VAR_EN
    tests_run++; if (out_illegal !== 1'b0 || out_b !== 5'd7 || out_left !== 1'b1) begin tests_failed++; $display("[TB] FAIL sllv: got ill=%0b b=%0d l=%0b expected 0 7 1", out_illegal, out_b, out_left); end
    in_instr = mk_instr(OPC_RTYPE, 5'd6, 5'd3, FUNCT_SRLV);
    @(negedge clk);
    tests_run++; if (out_illegal !== 1'b0 || out_b !== 5'd7 || out_left !== 1'b0) begin tests_failed++; $display("[TB] FAIL srlv: got ill=%0b b=%0d l=%0b expected 0 7 0", out_illegal, out_b, out_left); end
    exp_cnt += 2;
`else
    tests_run++; if (out_illegal !== 1'b1 || out_b !== 5'd0 || out_left !== 1'b0) begin tests_failed++; $display("[TB] FAIL sllv: got ill=%0b b=%0d l=%0b expected 1 0 0", out_illegal, out_b, out_left); end
    in_instr = mk_instr(OPC_RTYPE, 5'd6, 5'd3, FUNCT_SRLV);
    @(negedge clk);
    tests_run++; if (out_illegal !== 1'b1 || out_b !== 5'd0 || out_left !== 1'b0) begin tests_failed++; $display("[TB] FAIL srlv: got ill=%0b b=%0d l=%0b expected 1 0 0", out_illegal, out_b, out_left); end
`endif
    in_valid = 1'b0; in_rs = '0;
    @(negedge clk);
    tests_run++; if (shift_count !== 16'(exp_cnt)) begin tests_failed++; $display("[TB] FAIL var_count: got %0d expected %0d", shift_count, exp_cnt); end
  endtask

  task automatic test_reset_mid_stream();
    out_ready = 1'b0; in_rt = 32'h11111111;
    in_valid = 1'b1; in_instr = mk_instr(OPC_RTYPE, 5'd4, 5'd1, FUNCT_SLL);
    @(negedge clk);
    in_instr = mk_instr(OPC_RTYPE, 5'd4, 5'd2, FUNCT_SLL);
    @(negedge clk);
    tests_run++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_full: got ready=%0b valid=%0b expected 0 1", in_ready, out_valid); end
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 0;
    tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_reset_flags: got valid=%0b ready=%0b expected 0 1", out_valid, in_ready); end
    tests_run++; if (shift_count !== 16'd0 || sat_count !== 2'd0) begin tests_failed++; $display("[TB] FAIL mid_reset_count: got %0d/%0d expected 0/0", shift_count, sat_count); end
    out_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0 || shift_count !== 16'd0) begin tests_failed++; $display("[TB] FAIL mid_no_leak: got valid=%0b count=%0d expected 0 0", out_valid, shift_count); end
  endtask

  task automatic test_saturation();
    int exp_main;
    int exp_sat;
    out_ready = 1'b1; in_rt = 32'h00000001;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      exp_main = (i > 1) ? i - 1 : 0;
      exp_sat  = (exp_main > 3) ? 3 : exp_main;
      tests_run++; if (shift_count !== 16'(exp_main)) begin tests_failed++; $display("[TB] FAIL sat_main[%0d]: got %0d expected %0d", i, shift_count, exp_main); end
      tests_run++; if (sat_count !== 2'(exp_sat)) begin tests_failed++; $display("[TB] FAIL sat_small[%0d]: got %0d expected %0d", i, sat_count, exp_sat); end
      in_valid = (i < 5);
      in_instr = mk_instr(OPC_RTYPE, 5'd7, 5'(i + 1), FUNCT_SLL);
    end
  endtask

  initial begin
    test_reset();
    test_sll();
    test_backpressure();
    test_streaming();
    test_illegal();
    test_sllv();
    test_reset_mid_stream();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
